// File: rtl/ternary_sipo_ctrl.sv
// Ternary SIPO sequencer: packs LANES 2-bit coefs per word for an N-coef poly.
// Define TSIPO_ERRCHK_EN to flag (sticky err) and zero illegal code 2'b10.
module ternary_sipo_ctrl #(
  parameter int N     = 701,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_coef,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*LANES-1:0] out_word,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = $clog2(N);
  localparam int LW = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [CW-1:0]      coef_q, coef_d;
  logic [2*LANES-1:0] word_q, word_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic               accept;
  logic               bad;
  logic [1:0]         code;

  assign accept = (state_q == FILL) && in_valid;

`ifdef TSIPO_ERRCHK_EN
  assign bad  = (in_coef == 2'b10);
  assign code = bad ? 2'b00 : in_coef;
`else
  assign bad  = 1'b0;
  assign code = in_coef;
`endif

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    coef_d  = coef_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = err_q | (accept & bad);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          lane_d  = '0;
          coef_d  = '0;
          word_d  = '0;
          last_d  = 1'b0;
        end
      end
      FILL: begin
        if (accept) begin
          word_d[{lane_q, 1'b0} +: 2] = code;
          lane_d = lane_q + LW'(1);
          coef_d = coef_q + CW'(1);
          // final coef may leave upper lanes unwritten (still 00)
          if (coef_q == CW'(N - 1)) begin
            last_d  = 1'b1;
            state_d = HOLD;
          end else if (lane_q == LW'(LANES - 1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
            lane_d  = '0;
            word_d  = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        word_d  = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      coef_q  <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      coef_q  <= coef_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign busy      = in_ready | out_valid;
  assign done      = (state_q == DONE);
  assign out_word  = word_q;
  assign out_last  = last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ternary_sipo_ctrl.sv
// Bench for ternary_sipo_ctrl: word-level model plus directed scenarios.
// Follows TSIPO_ERRCHK_EN to choose the illegal-code expectation.
module tb_ternary_sipo_ctrl;

  localparam int N  = 701;
  localparam int L  = 4;
  localparam int NW = (N + L - 1) / L;
  localparam int W  = 2 * L;
`ifdef TSIPO_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
  localparam logic [7:0] W1BAD = 8'h41;
`else
  localparam bit ERRCHK = 1'b0;
  localparam logic [7:0] W1BAD = 8'h49;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, in_valid, in_ready;
  logic [1:0]   in_coef;
  logic         out_valid, out_ready, out_last;
  logic [W-1:0] out_word;
  logic         busy, done, err;

  logic         s_start, s_in_valid, s_in_ready;
  logic [1:0]   s_in_coef;
  logic         s_out_valid, s_out_ready, s_out_last;
  logic [7:0]   s_out_word;
  logic         s_busy, s_done, s_err;

  ternary_sipo_ctrl #(.N(N), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  ternary_sipo_ctrl #(.N(5), .LANES(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_coef(s_in_coef),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_word(s_out_word), .out_last(s_out_last),
    .busy(s_busy), .done(s_done), .err(s_err)
  );

  int tests   = 0;
  int fails   = 0;
  int cidx    = 0;
  int widx    = 0;
  int dones   = 0;
  int bad_idx = -1;
  bit errseen = 1'b0;
  bit acc_n   = 1'b0;
  bit oh_n    = 1'b0;

  function automatic logic [1:0] gen(int i);
    if (i == bad_idx) return 2'b10;
    case (i % 3)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] lane_val(logic [1:0] c);
    if (ERRCHK && c == 2'b10) return 2'b00;
    return c;
  endfunction

  // word k holds coefs k*L .. k*L+L-1, lanes past N are zero
  function automatic logic [W-1:0] exp_word(int k);
    logic [W-1:0] w;
    w = '0;
    for (int j = 0; j < L; j++)
      if (k * L + j < N) w[2*j +: 2] = lane_val(gen(k * L + j));
    return w;
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (acc_n) begin
      if (ERRCHK && gen(cidx) == 2'b10) errseen = 1'b1;
      cidx++;
    end
    if (oh_n) widx++;
    acc_n = 1'b0;
    oh_n  = 1'b0;
    #1 in_coef = gen(cidx);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      check("cmp_word", out_word, exp_word(widx));
      check("cmp_last", out_last, widx == NW - 1);
      check("cmp_inrdy", in_ready, 0);
    end
    check("cmp_err", err, errseen);
    if (done) begin
      check("cmp_done_words", widx, NW);
      dones++;
    end
    acc_n = rst_n && in_valid && in_ready;
    oh_n  = rst_n && out_valid && out_ready;
  end

  task automatic check_zero(string nm);
    check({nm, "_inrdy"}, in_ready, 0);
    check({nm, "_oval"}, out_valid, 0);
    check({nm, "_word"}, out_word, 0);
    check({nm, "_last"}, out_last, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_done"}, done, 0);
    check({nm, "_err"}, err, 0);
  endtask

  task automatic run_poly(bit do_stall, bit do_start, bit do_rst);
    int cyc;
    bit c0, c1, cl, stl, st1, st2;
    logic [W-1:0] hold;
    c0 = 0; c1 = 0; cl = 0; stl = 0; st1 = 0; st2 = 0;
    cidx = 0; widx = 0; dones = 0;
    in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (dones == 0 && cyc < 3000) begin
      if (!c0 && out_valid && widx == 0) begin
        c0 = 1;
        check("word0", out_word, 8'h34);
      end
      if (!c1 && out_valid && widx == 1 && bad_idx == 5) begin
        c1 = 1;
        check("word1_bad", out_word, W1BAD);
      end
      if (!cl && out_valid && widx == NW - 1) begin
        cl = 1;
        check("last_word", out_word, 8'h01);
        check("last_flag", out_last, 1);
      end
      if (do_stall && !stl && out_valid && widx == 10) begin
        stl = 1;
        out_ready = 1'b0;
        hold = out_word;
        check("stall_lit", hold, 8'h4D);
        repeat (10) begin
          step();
          check("stall_valid", out_valid, 1);
          check("stall_word", out_word, hold);
          check("stall_inrdy", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        check("stall_count", widx, 11);
        check("stall_oval", out_valid, 0);
      end
      if (do_start && !st1 && in_ready && widx == 20) begin
        st1 = 1;
        start = 1'b1;
      end
      if (do_start && !st2 && out_valid && widx == 30) begin
        st2 = 1;
        start = 1'b1;
      end
      if (do_rst && in_ready && widx == 50) begin
        #2 rst_n = 1'b0;
        errseen = 1'b0;
        #1 check_zero("midrst");
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        check("midrst_nodone", dones, 0);
        rst_n = 1'b1;
        cidx = 0;
        widx = 0;
        return;
      end
      step();
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 3000) begin
      tests++;
      fails++;
      $display("FAIL timeout: no done within %0d cycles", cyc);
    end
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_dones", dones, 1);
    check("post_words", widx, NW);
    check("post_coefs", cidx, N);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] sc [5];
    logic [7:0] sw [4];
    bit         sl [4];
    int         k, nw;
    bit         sfin, shs, soh;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_coef = 2'b00;
    s_start = 1'b0; s_in_valid = 1'b0;
    s_out_ready = 1'b0; s_in_coef = 2'b00;
    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    run_poly(0, 0, 0);
    run_poly(1, 0, 0);

    bad_idx = 5;
    run_poly(0, 0, 0);
    check("err_sticky", err, ERRCHK);
    bad_idx = -1;

    run_poly(0, 1, 0);
    check("err_after_start", err, ERRCHK);

    run_poly(0, 0, 1);
    check("rst_err", err, 0);
    run_poly(0, 0, 0);

    sc[0] = 2'b01; sc[1] = 2'b11; sc[2] = 2'b01;
    sc[3] = 2'b11; sc[4] = 2'b11;
    k = 0; nw = 0; sfin = 0;
    s_in_valid = 1'b1; s_out_ready = 1'b1; s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int cyc = 0; cyc < 40 && !sfin; cyc++) begin
      s_in_coef = sc[k];
      shs = s_in_valid && s_in_ready;
      soh = s_out_valid && s_out_ready;
      if (soh && nw < 4) begin
        sw[nw] = s_out_word;
        sl[nw] = s_out_last;
        nw++;
      end
      if (s_done) sfin = 1;
      else begin
        step();
        if (shs && k < 4) k++;
      end
    end
    check("small_done", sfin, 1);
    check("small_words", nw, 2);
    check("small_w0", sw[0], 8'hDD);
    check("small_l0", sl[0], 0);
    check("small_w1", sw[1], 8'h03);
    check("small_l1", sl[1], 1);
    check("small_err", s_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
